// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver. Both sides take
// their FSM encoding, frame length and tick count from here so that a TX/RX
// pair built with the same parameters frames identically.
//
// Contents:
//   uart_state_e  FSM state encoding (IDLE, START, DATA, [PARITY], STOP)
//   LINE_IDLE     level of the serial line between frames
//   PARITY_BITS   number of parity bits per frame (0 or 1)
//   calc_nticks   CLK cycles per line bit, Fclk/Bauds truncated
//   calc_wframe   line bits per frame
//
// Build option: define UART_PARITY_EN to add an even-parity bit after the
// data bits. TX and RX in one build must see the same setting.
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam logic LINE_IDLE = 1'b1;

`ifdef UART_PARITY_EN
   localparam int PARITY_BITS = 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;
`else
   localparam int PARITY_BITS = 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd4
   } uart_state_e;
`endif

   function automatic int calc_nticks(input int fclk, input int bauds);
      return fclk / bauds;
   endfunction

   function automatic int calc_wframe(input int wdata, input int wstop);
      return 1 + wdata + PARITY_BITS + wstop;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Reloadable bit-period down-counter. A load reloads the count to Nticks-1;
// the counter then runs down to zero and holds there. tick is high while the
// count is zero, i.e. during the last CLK cycle of a bit.
//
// Ports:
//   clk    in   1   clock
//   rst_n  in   1   asynchronous active-low reset (count cleared)
//   load   in   1   start a new bit period on this edge
//   tick   out  1   last cycle of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_tick #(
   parameter int Nticks = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic tick
);

   localparam int CW = (Nticks > 1) ? $clog2(Nticks) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = CW'(Nticks - 1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter. Sends start bit, Wdata data bits LSB first, an optional
// even-parity bit and Wstop stop bits; every bit lasts Fclk/Bauds CLK cycles.
// The host hands over words with a valid/ready handshake; a word accepted in
// the final stop cycle follows the current frame with no idle gap.
//
// Ports:
//   CLK    in   1      system clock
//   RST_N  in   1      asynchronous active-low reset; line returns high at once
//   DIN    in   Wdata  word to send, sampled only on accept
//   STB    in   1      host offers DIN
//   RDY    out  1      transmitter can accept (accept = STB && RDY at posedge)
//   TXD    out  1      serial line, registered, idle high
//
// Build option: UART_PARITY_EN adds the PARITY state (even parity over the
// latched word) between DATA and STOP.
// -----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int Bauds = 115200,
   parameter int Wdata = 8,
   parameter int Wstop = 1,
   parameter int Fclk  = 12000000
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [Wdata-1:0] DIN,
   input  logic             STB,
   output logic             RDY,
   output logic             TXD
);

   localparam int NTICKS = calc_nticks(Fclk, Bauds);
   localparam int IW     = $clog2(Wdata + 1);

   uart_state_e      state_q, state_d;
   logic [Wdata-1:0] shift_q, shift_d;
   logic [IW-1:0]    idx_q,   idx_d;
   logic             txd_q,   txd_d;
`ifdef UART_PARITY_EN
   logic             par_q,   par_d;
`endif

   logic load;
   logic tick;
   logic last_stop;
   logic accept;

   uart_baud_tick #(
      .Nticks (NTICKS)
   ) u_baud_tick (
      .clk   (CLK),
      .rst_n (RST_N),
      .load  (load),
      .tick  (tick)
   );

   // Ready in the last cycle of the last stop bit lets the next start bit
   // follow directly.
   assign last_stop = (state_q == ST_STOP) && tick && (idx_q == IW'(Wstop - 1));
   assign RDY       = (state_q == ST_IDLE) || last_stop;
   assign accept    = STB && RDY;
   assign TXD       = txd_q;

   // txd_d is the line level for the cycle after this edge, so TXD always
   // changes together with the state it belongs to.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      txd_d   = txd_q;
      load    = 1'b0;
`ifdef UART_PARITY_EN
      par_d   = par_q;
`endif

      case (state_q)
         ST_IDLE: begin
            txd_d = LINE_IDLE;
         end

         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
               idx_d   = '0;
               txd_d   = shift_q[0];
               load    = 1'b1;
            end
         end

         ST_DATA: begin
            if (tick) begin
               load = 1'b1;
               if (idx_q == IW'(Wdata - 1)) begin
                  idx_d = '0;
`ifdef UART_PARITY_EN
                  state_d = ST_PARITY;
                  txd_d   = par_q;
`else
                  state_d = ST_STOP;
                  txd_d   = LINE_IDLE;
`endif
               end else begin
                  // Current bit sits in shift_q[0]; the next one is bit 1.
                  idx_d   = idx_q + IW'(1);
                  shift_d = shift_q >> 1;
                  txd_d   = shift_q[1];
               end
            end
         end

`ifdef UART_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
               idx_d   = '0;
               txd_d   = LINE_IDLE;
               load    = 1'b1;
            end
         end
`endif

         ST_STOP: begin
            if (tick) begin
               txd_d = LINE_IDLE;
               if (idx_q == IW'(Wstop - 1)) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d = idx_q + IW'(1);
                  load  = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            txd_d   = LINE_IDLE;
         end
      endcase

      // Accept is only possible in IDLE or the final stop cycle; in both
      // cases a new frame starts on this edge.
      if (accept) begin
         state_d = ST_START;
         shift_d = DIN;
         idx_d   = '0;
         txd_d   = ~LINE_IDLE;
         load    = 1'b1;
`ifdef UART_PARITY_EN
         par_d   = ^DIN;
`endif
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         txd_q   <= LINE_IDLE;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         txd_q   <= txd_d;
      end
   end

   // Word and parity are only meaningful once a frame is accepted.
   always_ff @(posedge CLK) begin
      shift_q <= shift_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
   end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
module tb_uart_tx;

   localparam int NT  = 16;
   localparam int WD  = 8;
`ifdef UART_PARITY_EN
   localparam int PB  = 1;
`else
   localparam int PB  = 0;
`endif
   localparam int WF  = 1 + WD + PB + 1;
   localparam int WF2 = 1 + WD + PB + 2;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          STB, STB2;
   logic [WD-1:0] DIN, DIN2;
   logic          RDY, TXD, RDY2, TXD2;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   bit            rx_en = 1'b0;
   logic [WD-1:0] sb_q[$];

   typedef struct {
      logic [WD-1:0] din;
      logic [8:0]    exp_head;   // start bit then data bits, line order from bit 0
      logic          exp_par;
   } vec_t;

   vec_t tbl[8];

   uart_tx #(.Bauds(100000), .Wdata(WD), .Wstop(1), .Fclk(1600000)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .STB(STB), .RDY(RDY), .TXD(TXD));

   uart_tx #(.Bauds(100000), .Wdata(WD), .Wstop(2), .Fclk(1600000)) u_dut2 (
      .CLK(CLK), .RST_N(RST_N), .DIN(DIN2), .STB(STB2), .RDY(RDY2), .TXD(TXD2));

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: line level of frame bit b for word w.
   function automatic logic exp_bit(input logic [WD-1:0] w, input int b);
      if (b == 0) return 1'b0;
      if (b <= WD) return w[b-1];
`ifdef UART_PARITY_EN
      if (b == WD + 1) return ^w;
`endif
      return 1'b1;
   endfunction

   // Waits (bounded) for RDY, then offers w for one cycle. Returns at the
   // negedge of the first cycle after the accept edge.
   task automatic send(input logic [WD-1:0] w, input int gap);
      int t = 0;
      while (RDY !== 1'b1 && t < 2 * WF * NT) begin
         @(negedge CLK);
         t++;
      end
      chk("send rdy wait", 32'(RDY), 32'd1);
      repeat (gap) @(negedge CLK);
      STB = 1'b1;
      DIN = w;
      if (rx_en) sb_q.push_back(w);
      @(negedge CLK);
      STB = 1'b0;
      DIN = WD'($urandom);
   endtask

   // Checks a whole frame cycle by cycle starting at cycle 0; stops at the
   // negedge of the last frame cycle. Optionally pulses STB=3C at pulse_at.
   task automatic watch_frame(input logic [WD-1:0] w, input string tag, input int pulse_at);
      for (int c = 0; c < WF * NT; c++) begin
         chk({tag, " txd"}, 32'(TXD), 32'(exp_bit(w, c / NT)));
         chk({tag, " rdy"}, 32'(RDY), 32'(c == WF * NT - 1));
         if (pulse_at >= 0) begin
            if (c == pulse_at) begin
               STB = 1'b1;
               DIN = 8'h3C;
            end else if (c == pulse_at + 1) begin
               STB = 1'b0;
            end
         end
         if (c != WF * NT - 1) @(negedge CLK);
      end
   endtask

   // Behavioural line receiver, mid-bit sampling, checked against sb_q.
   initial begin : rx_model
      logic [WD-1:0] w;
      forever begin
         @(negedge CLK);
         if (rx_en && TXD === 1'b0) begin
            repeat (NT / 2) @(negedge CLK);
            chk("rx start", 32'(TXD), 32'd0);
            for (int i = 0; i < WD; i++) begin
               repeat (NT) @(negedge CLK);
               w[i] = TXD;
            end
`ifdef UART_PARITY_EN
            repeat (NT) @(negedge CLK);
            chk("rx parity", 32'(TXD), 32'(^w));
`endif
            repeat (NT) @(negedge CLK);
            chk("rx stop", 32'(TXD), 32'd1);
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL rx word: got %0h, expected none pending", w);
            end else begin
               chk("rx word", 32'(w), 32'(sb_q.pop_front()));
            end
         end
      end
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      int t0, t1, t, n_stop;
      tbl[0] = '{8'hA5, 9'h14A, 1'b0};
      tbl[1] = '{8'h00, 9'h000, 1'b0};
      tbl[2] = '{8'hFF, 9'h1FE, 1'b0};
      tbl[3] = '{8'h3C, 9'h078, 1'b0};
      tbl[4] = '{8'h81, 9'h102, 1'b0};
      tbl[5] = '{8'h5A, 9'h0B4, 1'b0};
      tbl[6] = '{8'h07, 9'h00E, 1'b1};
      tbl[7] = '{8'h01, 9'h002, 1'b1};

      RST_N = 1'b0;
      STB   = 1'b0;
      STB2  = 1'b0;
      DIN   = '0;
      DIN2  = '0;
      repeat (3) @(negedge CLK);
      chk("reset txd", 32'(TXD), 32'd1);
      chk("reset rdy", 32'(RDY), 32'd1);
      chk("reset txd2", 32'(TXD2), 32'd1);
      RST_N = 1'b1;

      // Idle after reset
      for (int c = 0; c < 500; c++) begin
         @(negedge CLK);
         chk("idle txd", 32'(TXD), 32'd1);
         chk("idle rdy", 32'(RDY), 32'd1);
      end

      // Single byte A5
      send(8'hA5, 0);
      watch_frame(8'hA5, "a5", -1);
      @(negedge CLK);
      chk("a5 after txd", 32'(TXD), 32'd1);
      chk("a5 after rdy", 32'(RDY), 32'd1);

      // Table-driven frames
      for (int i = 0; i < 8; i++) begin
         send(tbl[i].din, i % 3);
         for (int c = 0; c < WF * NT; c++) begin
            int   b;
            logic e;
            b = c / NT;
            if (b < 9) e = tbl[i].exp_head[b];
`ifdef UART_PARITY_EN
            else if (b == 9) e = tbl[i].exp_par;
`endif
            else e = 1'b1;
            chk("tbl txd", 32'(TXD), 32'(e));
            chk("tbl rdy", 32'(RDY), 32'(c == WF * NT - 1));
            @(negedge CLK);
         end
      end

      // Back-to-back with STB held
      repeat (3) @(negedge CLK);
      STB = 1'b1;
      DIN = 8'h00;
      t0  = cyc;
      @(negedge CLK);
      DIN = 8'hFF;
      t   = 0;
      while (RDY !== 1'b1 && t < 4 * WF * NT) begin
         @(negedge CLK);
         t++;
      end
      t1 = cyc;
      chk("b2b accept period", 32'(t1 - t0), 32'(WF * NT));
      chk("b2b stop level", 32'(TXD), 32'd1);
      @(negedge CLK);
      STB = 1'b0;
      watch_frame(8'hFF, "b2b second", -1);
      @(negedge CLK);

      // Strobe while busy is ignored
      send(8'h96, 1);
      watch_frame(8'h96, "ignored stb", 50);
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         chk("ignored idle txd", 32'(TXD), 32'd1);
         chk("ignored idle rdy", 32'(RDY), 32'd1);
      end

      // Two stop bits
      STB2 = 1'b1;
      DIN2 = 8'hA5;
      @(negedge CLK);
      STB2   = 1'b0;
      n_stop = 0;
      for (int c = 0; c < WF2 * NT; c++) begin
         chk("wstop2 txd", 32'(TXD2), 32'(exp_bit(8'hA5, c / NT)));
         chk("wstop2 rdy", 32'(RDY2), 32'(c == WF2 * NT - 1));
         if (c / NT > WD + PB && TXD2 === 1'b1) n_stop++;
         @(negedge CLK);
      end
      chk("wstop2 stop cycles", 32'(n_stop), 32'd32);
      chk("wstop2 idle txd", 32'(TXD2), 32'd1);

      // Reset during data bit 3
      send(8'hC3, 0);
      repeat (70) @(negedge CLK);
      chk("pre-reset txd", 32'(TXD), 32'd0);
      chk("pre-reset rdy", 32'(RDY), 32'd0);
      #2 RST_N = 1'b0;
      #1;
      chk("async reset txd", 32'(TXD), 32'd1);
      chk("async reset rdy", 32'(RDY), 32'd1);
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      send(8'h5A, 0);
      watch_frame(8'h5A, "post-reset 5a", -1);
      @(negedge CLK);

      // Random loopback with scoreboard
      rx_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         send(WD'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      t = 0;
      while (sb_q.size() != 0 && t < 3 * WF * NT) begin
         @(negedge CLK);
         t++;
      end
      chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
      rx_en = 1'b0;
      repeat (4) @(negedge CLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
